// File: rtl/gshare_branch_predictor.sv
// Gshare branch predictor: direct-mapped BTB plus a PHT of 2-bit counters indexed by PC xor GHR.
// Lookup is combinational from registered tables; resolved branches train the tables on the clock edge.
module gshare_branch_predictor #(
    parameter int unsigned INDEX_BITS = 6,
    parameter int unsigned HIST_BITS  = 4,
    parameter int unsigned TAG_BITS   = 8
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] Fetch_PC,
    output logic        Pred_Hit,
    output logic        Request_Alt_PC,
    output logic [31:0] Alt_PC,
    input  logic        Update_Valid,
    input  logic [31:0] Update_PC,
    input  logic        Update_Taken,
    input  logic [31:0] Update_Target,
    output logic [15:0] Stat_Updates,
    output logic [15:0] Stat_Mispredicts
);

    localparam int unsigned ENTRIES  = 1 << INDEX_BITS;
    localparam int unsigned TAG_LSB  = INDEX_BITS + 2;
    localparam int unsigned TAG_MSB  = INDEX_BITS + TAG_BITS + 1;
    localparam logic [15:0] STAT_MAX = 16'hFFFF;

    logic [1:0]          pht        [ENTRIES];
    logic                btb_valid  [ENTRIES];
    logic [TAG_BITS-1:0] btb_tag    [ENTRIES];
    logic [31:0]         btb_target [ENTRIES];
    logic [HIST_BITS-1:0] ghr;
    logic [HIST_BITS-1:0] ghr_next;

    logic [INDEX_BITS-1:0] fetch_bidx;
    logic [INDEX_BITS-1:0] fetch_pidx;
    logic [TAG_BITS-1:0]   fetch_tag;
    logic [INDEX_BITS-1:0] upd_bidx;
    logic [INDEX_BITS-1:0] upd_pidx;
    logic [TAG_BITS-1:0]   upd_tag;
    logic [1:0]            upd_cnt;
    logic                  upd_mispredict;

    // Upper PC bits beyond tag and the byte offset do not participate in prediction.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{Fetch_PC, Update_PC};

    assign fetch_bidx = Fetch_PC[INDEX_BITS+1:2];
    assign fetch_tag  = Fetch_PC[TAG_MSB:TAG_LSB];
    assign fetch_pidx = fetch_bidx ^ INDEX_BITS'(ghr);
    assign upd_bidx   = Update_PC[INDEX_BITS+1:2];
    assign upd_tag    = Update_PC[TAG_MSB:TAG_LSB];
    assign upd_pidx   = upd_bidx ^ INDEX_BITS'(ghr);

    // Same-cycle lookup path from the registered tables.
    always_comb begin
        Pred_Hit       = btb_valid[fetch_bidx] && (btb_tag[fetch_bidx] == fetch_tag);
        Request_Alt_PC = Pred_Hit && pht[fetch_pidx][1];
        Alt_PC         = Request_Alt_PC ? btb_target[fetch_bidx] : 32'd0;
    end

    // Saturating counter step and mispredict flag, both from pre-update contents.
    always_comb begin
        upd_cnt        = pht[upd_pidx];
        upd_mispredict = pht[upd_pidx][1] != Update_Taken;
        if (Update_Taken && (pht[upd_pidx] != 2'b11)) begin
            upd_cnt = pht[upd_pidx] + 2'd1;
        end else if (!Update_Taken && (pht[upd_pidx] != 2'b00)) begin
            upd_cnt = pht[upd_pidx] - 2'd1;
        end
    end

    generate
        if (HIST_BITS == 1) begin : g_ghr_one
            assign ghr_next = HIST_BITS'(Update_Taken);
        end else begin : g_ghr_shift
            assign ghr_next = {ghr[HIST_BITS-2:0], Update_Taken};
        end
    endgenerate

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                pht[i]        <= 2'b01;
                btb_valid[i]  <= 1'b0;
                btb_tag[i]    <= '0;
                btb_target[i] <= '0;
            end
            ghr              <= '0;
            Stat_Updates     <= '0;
            Stat_Mispredicts <= '0;
        end else if (Update_Valid) begin
            pht[upd_pidx] <= upd_cnt;
            ghr           <= ghr_next;
            if (Update_Taken) begin
                btb_valid[upd_bidx]  <= 1'b1;
                btb_tag[upd_bidx]    <= upd_tag;
                btb_target[upd_bidx] <= Update_Target;
            end
            if (Stat_Updates != STAT_MAX) begin
                Stat_Updates <= Stat_Updates + 16'd1;
            end
            if (upd_mispredict && (Stat_Mispredicts != STAT_MAX)) begin
                Stat_Mispredicts <= Stat_Mispredicts + 16'd1;
            end
        end
    end

endmodule

// File: doc/gshare_branch_predictor.md
# gshare_branch_predictor

Dynamic branch predictor sitting directly upstream of the IF stage. Each cycle it looks up the current fetch PC in a direct-mapped branch target buffer (BTB) and a gshare pattern history table (PHT) of 2-bit saturating counters. It drives an alternate-PC request that IF uses to redirect fetch. Branch outcomes resolved in MEM are fed back on the update port to train the tables and the global history register (GHR).

## Interface
- INDEX_BITS, 6: log2 of the BTB and PHT entry count (64 entries).
- HIST_BITS, 4: GHR width; legal range 1..INDEX_BITS.
- TAG_BITS, 8: BTB tag width; INDEX_BITS+TAG_BITS+2 <= 32.
- CLK  in  1  single clock; all state changes on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- Fetch_PC  in  32  PC IF presents to instruction memory this cycle.
- Pred_Hit  out  1  BTB entry valid and tag matches Fetch_PC.
- Request_Alt_PC  out  1  predict taken; IF must fetch Alt_PC next.
- Alt_PC  out  32  predicted target; 0 when Request_Alt_PC=0.
- Update_Valid  in  1  one resolved branch/jump this cycle.
- Update_PC  in  32  PC of the resolved instruction.
- Update_Taken  in  1  resolved direction.
- Update_Target  in  32  resolved target; meaningful only when Update_Taken=1.
- Stat_Updates  out  16  count of accepted updates; saturates at 0xFFFF.
- Stat_Mispredicts  out  16  count of updates whose indexed counter MSB differed from Update_Taken; saturates at 0xFFFF.

## Operation
- Fields: bidx(PC) = PC[INDEX_BITS+1:2]; tag(PC) = PC[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2]; pidx(PC) = bidx(PC) XOR zero-extended GHR.
- Lookup is combinational from registered tables.
  - Pred_Hit = btb_valid[bidx] && btb_tag[bidx]==tag(Fetch_PC).
  - Request_Alt_PC = Pred_Hit && pht[pidx(Fetch_PC)][1].
  - Alt_PC = Request_Alt_PC ? btb_target[bidx] : 0.
- Update applies at the clock edge when Update_Valid=1. It uses the GHR value before that edge.
  - PHT[pidx(Update_PC)]: taken increments and saturates at 11; not-taken decrements and saturates at 00.
  - GHR <= {GHR[HIST_BITS-2:0], Update_Taken}. For HIST_BITS=1, GHR <= Update_Taken.
  - If taken: btb_valid[bidx] <= 1, tag <= tag(Update_PC), target <= Update_Target. Conflicting entries are overwritten.
  - If not taken: BTB unchanged.
  - Stat_Updates increments. Stat_Mispredicts increments if the pre-update PHT[pidx(Update_PC)][1] != Update_Taken. Both counters hold at 0xFFFF.
- The GHR is non-speculative: only the update port changes it. Lookups have no side effects, so IF stalls need no input here.
- Counter encoding: 00 strongly not-taken, 01 weakly not-taken, 10 weakly taken, 11 strongly taken.

## Timing
- Reset values:
  - All PHT counters 01.
  - All btb_valid 0; tags and targets 0.
  - GHR 0; both Stat counters 0.
  - Consequently Pred_Hit=0, Request_Alt_PC=0, Alt_PC=0 while RESET is high. This holds immediately, with no clock edge required.
- Lookup latency is 0 cycles (same-cycle combinational). Update latency is 1 edge.
- Simultaneous lookup and update of the same entry: the lookup returns pre-update contents. The new contents are visible on the cycle after the edge.
- GHR change and lookup: a lookup in the same cycle as an update uses the old GHR. The next cycle uses the shifted GHR.
- Reset asserted mid-operation aborts any pending update at that edge. All state returns to reset values asynchronously.
- Reset deassertion is synchronous to CLK by the surrounding design. The first update is accepted on the first rising edge with RESET low.

## Test plan
- Reset check: assert RESET with no clock, Fetch_PC=0x00400010 -> Pred_Hit=0, Request_Alt_PC=0, Alt_PC=0, both Stat counters 0.
- Warm-up through history (defaults):
  - Stimulus: 5 updates of PC=0x00400010, taken, target 0x00400100. These train PHT indices 4, 5, 7, 3, then 0xB; GHR ends at 1111.
  - Lookup 0x00400010 after update 1 -> Pred_Hit=1, Request_Alt_PC=0 (index 5 reads 01).
  - Lookup after update 5 -> Request_Alt_PC=1, Alt_PC=0x00400100.
  - Stat_Updates=5, Stat_Mispredicts=5.
- Saturation and hysteresis:
  - Stimulus: continue with 2 more taken updates, then 1 not-taken.
  - PHT[0xB] goes 10 -> 11 -> 11, then 10 on the not-taken update; GHR=1110.
  - Lookup 0x00400010 -> index 0xA (counter 01) -> Request_Alt_PC=0, Pred_Hit=1.
- Tag mismatch: after the warm-up, lookup 0x00400110 (same bidx 4, tag 0x01) -> Pred_Hit=0, Request_Alt_PC=0, Alt_PC=0.
- Same-cycle collision: drive Update_Valid=1 and a lookup on an entry whose counter is 01, in the same cycle as the update making it 10.
  - That cycle: the lookup reflects 01.
  - Next cycle: with GHR held so the index is the same, the lookup reflects 10 and Request_Alt_PC=1.
- Mid-operation reset: with a trained BTB, pulse RESET between edges while Update_Valid=1 -> outputs drop to 0 immediately. Post-reset lookups miss and both Stat counters read 0.
